// File: rtl/bm_arbiter_rr_param_if.sv
// Request and transfer-control bundle between the bus-matrix input stages
// and the output-stage arbiter.
interface bm_arbiter_rr_param_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) ();
    logic [NUM_PORTS-1:0] req_port;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [PORT_W-1:0]    addr_in_port;
    logic                 no_port;
    logic                 burst_hold;

    modport slave (
        input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port, burst_hold
    );

    modport master (
        output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port, burst_hold
    );
endinterface

// File: rtl/bm_arbiter_rr_param.sv
// Bus-matrix output-stage arbiter: round-robin or fixed priority, holding the
// grant for the length of a burst and dropping INCR hold after early termination.
module bm_arbiter_rr_param #(
    parameter int                   NUM_PORTS   = 4,
    parameter int                   PORT_W      = 2,
    parameter logic [NUM_PORTS-1:0] PORT_MASK   = 4'b1011,
    parameter int                   ARB_MODE    = 1,
    parameter int                   INCR_BEATS  = 4,
    parameter int                   EARLY_LIMIT = 1
) (
    input logic                  HCLK,
    input logic                  HRESETn,
    bm_arbiter_rr_param_if.slave bus
);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_e;

    htrans_e              trans;
    logic [NUM_PORTS-1:0] req_v;

    logic [3:0]           remain_q, remain_d;
    logic                 hold_q, hold_d;
    logic [1:0]           early_q, early_d, early_inc;

    logic [PORT_W-1:0]    grant_q, grant_d;
    logic                 no_port_q, no_port_d;

    logic                 lo_any_found, lo_oth_found, rr_found;
    logic [PORT_W-1:0]    lo_any_idx, lo_oth_idx, rr_idx;
    logic                 other_found;
    logic [PORT_W-1:0]    other_idx;
    int unsigned          rr_k;

    assign trans = htrans_e'(bus.HTRANSM);
    assign req_v = bus.req_port & PORT_MASK;

    // The early limit is compared against the count including the NONSEQ now
    // on the bus, so the first restart after a cut-short INCR loses its hold.
    always_comb begin
        remain_d  = remain_q;
        hold_d    = hold_q;
        early_inc = early_q;
        if (hold_q && trans == TR_NONSEQ && early_q != 2'd3) begin
            early_inc = early_q + 2'd1;
        end

        if (!bus.HSELM || trans == TR_IDLE) begin
            remain_d = '0;
            hold_d   = 1'b0;
        end else begin
            case (trans)
                TR_NONSEQ: begin
                    casez (bus.HBURSTM)
                        3'b000: begin
                            remain_d = '0;
                            hold_d   = 1'b0;
                        end
                        3'b001: begin
                            if (early_inc == 2'(EARLY_LIMIT)) begin
                                remain_d = '0;
                                hold_d   = 1'b0;
                            end else begin
                                remain_d = 4'(INCR_BEATS - 2);
                                hold_d   = 1'b1;
                            end
                        end
                        3'b01?: begin
                            remain_d = 4'd2;
                            hold_d   = 1'b1;
                        end
                        3'b10?: begin
                            remain_d = 4'd6;
                            hold_d   = 1'b1;
                        end
                        default: begin
                            remain_d = 4'd14;
                            hold_d   = 1'b1;
                        end
                    endcase
                end
                TR_SEQ: begin
                    if (remain_q == '0) begin
                        remain_d = '0;
                        hold_d   = 1'b0;
                    end else begin
                        remain_d = remain_q - 4'd1;
                    end
                end
                default: begin
                    remain_d = remain_q;
                    hold_d   = hold_q;
                end
            endcase
        end

        early_d = hold_d ? early_inc : '0;
    end

    always_comb begin
        lo_any_found = 1'b0;
        lo_any_idx   = '0;
        lo_oth_found = 1'b0;
        lo_oth_idx   = '0;
        rr_found     = 1'b0;
        rr_idx       = '0;
        rr_k         = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!lo_any_found && req_v[i]) begin
                lo_any_found = 1'b1;
                lo_any_idx   = PORT_W'(i);
            end
            if (!lo_oth_found && req_v[i] && i != 32'(grant_q)) begin
                lo_oth_found = 1'b1;
                lo_oth_idx   = PORT_W'(i);
            end
        end
        for (int unsigned i = 1; i < NUM_PORTS; i++) begin
            rr_k = (32'(grant_q) + i) % NUM_PORTS;
            if (!rr_found && req_v[rr_k]) begin
                rr_found = 1'b1;
                rr_idx   = PORT_W'(rr_k);
            end
        end
    end

    always_comb begin
        other_found = (ARB_MODE != 0) ? rr_found : lo_oth_found;
        other_idx   = (ARB_MODE != 0) ? rr_idx   : lo_oth_idx;
        grant_d     = grant_q;
        no_port_d   = no_port_q;
        if (bus.HMASTLOCKM || hold_d) begin
            no_port_d = 1'b0;
        end else if (no_port_q) begin
            if (lo_any_found) begin
                grant_d   = lo_any_idx;
                no_port_d = 1'b0;
            end
        end else if (other_found) begin
            grant_d   = other_idx;
            no_port_d = 1'b0;
        end else begin
            no_port_d = !bus.HSELM;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            remain_q  <= '0;
            hold_q    <= 1'b0;
            early_q   <= '0;
            grant_q   <= '0;
            no_port_q <= 1'b1;
        end else if (bus.HREADYM) begin
            remain_q  <= remain_d;
            hold_q    <= hold_d;
            early_q   <= early_d;
            grant_q   <= grant_d;
            no_port_q <= no_port_d;
        end
    end

    assign bus.addr_in_port = grant_q;
    assign bus.no_port      = no_port_q;
    assign bus.burst_hold   = hold_q;

endmodule
